debug_inst_loader: RTL and testbench
====================================

Name: debug_inst_loader

Overview:
- Debug-side loader that sits directly upstream of the CPU top-level instruction-memory write port.
- Consumes the byte stream from the UART receiver and parses a LOAD command.
- Assembles little-endian 32-bit instruction words and drives the instruction-memory write enable, address and data.
- Holds the CPU pipeline in reset for the whole load.

Parameters:
- NBITS, 32, instruction word and address width.
- MAX_WORDS, 256, maximum accepted word count; larger counts are rejected.
- CMD_LOAD, 8'h4C, command byte that starts a load.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous active-high reset
- i_rx_data  in  8  received UART byte
- i_rx_valid  in  1  one-cycle strobe; i_rx_data valid
- o_inst_mem_wr_en  out  1  one-cycle instruction-memory write pulse
- o_inst_mem_addr  out  NBITS  byte address of the word being written
- o_inst_mem_data  out  NBITS  assembled instruction word
- o_cpu_rst  out  1  pipeline hold-in-reset, high while loading
- o_busy  out  1  high in any state other than IDLE
- o_done  out  1  one-cycle pulse on successful load completion
- o_err  out  1  one-cycle pulse on protocol error

Behaviour:
- Reset and clocking:
  - One clock, i_clk. Reset i_rst is synchronous and active-high.
  - On reset: state = IDLE; word index = 0; byte counter = 0; word count = 0.
  - On reset all outputs are 0: o_inst_mem_wr_en, o_inst_mem_addr, o_inst_mem_data, o_cpu_rst, o_busy, o_done, o_err.
  - Reset mid-load aborts immediately. Words already written stay in memory. No o_done or o_err is issued.
- Byte acceptance:
  - A byte is accepted in any cycle with i_rx_valid = 1.
  - Bytes arriving on consecutive cycles are all accepted. No back-pressure exists.
- States:
  - IDLE:
    - Byte == CMD_LOAD -> CNT_LO.
    - Any other byte -> o_err pulse next cycle; stay in IDLE.
  - CNT_LO: latch count[7:0] -> CNT_HI.
  - CNT_HI: latch count[15:8], then check the count:
    - count > MAX_WORDS -> o_err pulse; go to IDLE.
    - count == 0 -> finish (see completion rules).
    - otherwise -> DATA.
  - DATA:
    - Bytes are shifted in little-endian: the first byte goes to [7:0], the fourth to [31:24].
    - On the 4th byte, the next cycle gives:
      - o_inst_mem_data = assembled word;
      - o_inst_mem_addr = index << 2;
      - o_inst_mem_wr_en = 1 for exactly one cycle.
    - The index then increments and the byte counter wraps to 0.
    - o_inst_mem_addr and o_inst_mem_data hold their values until the next write.
    - After the write of word count-1 -> finish.
- Completion:
  - Finish without CHECKSUM_EN: o_done pulses in the same cycle as the last write pulse; state returns to IDLE.
  - For count == 0, o_done pulses one cycle after the CNT_HI byte.
- Status outputs:
  - o_cpu_rst and o_busy are registered and high from the cycle after CMD_LOAD is accepted until the cycle after return to IDLE.
  - o_done and o_err are never asserted together.
- Address arithmetic: index is 16 bits, zero-extended and shifted left by 2 into NBITS. Index never exceeds MAX_WORDS-1.

Optional Feature:
- Macro: DEBUG_LOADER_CHECKSUM_EN.
- Defined:
  - After the last data byte, or after CNT_HI when count == 0, the FSM enters state CHK and waits for one checksum byte.
  - Expected checksum = XOR of all data bytes; 8'h00 when count == 0.
  - Match -> o_done pulse the cycle after the checksum byte. Mismatch -> o_err pulse. Either way, return to IDLE.
  - The write pulse for the last word still occurs normally.
- Undefined: state CHK and the XOR accumulator are absent; completion follows the rules in Behaviour.

Decomposition:
- Shared package/header debug_pkg:
  - state encodings IDLE, CNT_LO, CNT_HI, DATA, CHK;
  - CMD_LOAD default;
  - byte-width constant.
- One natural sub-module: byte_word_assembler. It holds the 4-byte shift register and the 2-bit byte counter, and outputs a word_ready strobe.

Test Plan:
- Reset mid-DATA: send 4C 02 00 AA, then assert i_rst -> all outputs 0 next cycle; the next 4C starts a fresh load at address 0.
- Basic load: send 4C 02 00 78 56 34 12 EF BE AD DE ->
  - write 0x12345678 @ 0x0, then 0xDEADBEEF @ 0x4, each wr_en one cycle;
  - o_done pulses with the second write;
  - o_cpu_rst high throughout.
- Bad command: send 0x55 in IDLE -> o_err one cycle; no write; o_busy stays 0.
- Count bounds:
  - count 0x0101 (257) -> o_err; return to IDLE.
  - count 0 -> o_done one cycle after CNT_HI; no write.
- Back-to-back bytes: 4C 01 00 01 02 03 04 on consecutive cycles -> single write of 0x04030201 @ 0x0, one cycle after the 4th data byte.
- With DEBUG_LOADER_CHECKSUM_EN: 4C 01 00 01 02 03 04 04 -> write, then o_done. The same stream with a final byte 05 -> write, then o_err, no o_done.

Source files
------------

// File: rtl/debug_pkg.sv
// Shared definitions for the debug instruction loader.
//   state_e      : loader FSM state encodings
//   BYTE_W       : width of one UART byte
//   CMD_LOAD_DEF : default command byte that starts a load
package debug_pkg;

  localparam int BYTE_W = 8;

  localparam logic [BYTE_W-1:0] CMD_LOAD_DEF = 8'h4C;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CNT_LO = 3'd1,
    CNT_HI = 3'd2,
    DATA   = 3'd3,
    CHK    = 3'd4
  } state_e;

endpackage

// File: rtl/debug_inst_loader_byte_word_assembler.sv
// byte_word_assembler: collects four bytes little-endian into one word.
// Ports:
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_clear        : forces the byte counter back to 0 (loader idle)
//   i_byte         : incoming byte
//   i_valid        : i_byte is a data byte to be shifted in
//   o_word         : assembled word, valid while o_word_ready is high
//   o_word_ready   : combinational strobe, high on the 4th byte of a word
module byte_word_assembler
  import debug_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic [BYTE_W-1:0] i_byte,
  input  logic              i_valid,
  output logic [31:0]       o_word,
  output logic              o_word_ready
);

  logic [31:0] sh_q;
  logic [1:0]  cnt_q;

  // Bytes enter at the top and move down, so after three bytes sh_q[31:8]
  // holds {b2, b1, b0}; the 4th byte completes the word without waiting for
  // the register update.
  assign o_word       = {i_byte, sh_q[31:8]};
  assign o_word_ready = i_valid && (cnt_q == 2'd3);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      cnt_q <= 2'd0;
    end else if (i_valid) begin
      cnt_q <= cnt_q + 2'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_valid) begin
      sh_q <= {i_byte, sh_q[31:8]};
    end
  end

endmodule

// File: rtl/debug_inst_loader.sv
// debug_inst_loader: parses a LOAD command from the UART byte stream and
// writes little-endian 32-bit words into instruction memory while holding
// the CPU pipeline in reset.
// Stream: CMD_LOAD, count[7:0], count[15:8], count*4 data bytes
//         (+ one XOR checksum byte when DEBUG_LOADER_CHECKSUM_EN is defined).
// Ports:
//   i_clk, i_rst          : clock, synchronous active-high reset
//   i_rx_data, i_rx_valid : received byte and its one-cycle strobe
//   o_inst_mem_wr_en      : one-cycle write pulse
//   o_inst_mem_addr/data  : byte address and word, held between writes
//   o_cpu_rst, o_busy     : high while a load is in progress
//   o_done, o_err         : one-cycle completion / protocol-error pulses
// Optional macro: DEBUG_LOADER_CHECKSUM_EN adds the CHK state and XOR check.
module debug_inst_loader
  import debug_pkg::*;
#(
  parameter int                NBITS     = 32,
  parameter int                MAX_WORDS = 256,
  parameter logic [BYTE_W-1:0] CMD_LOAD  = CMD_LOAD_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [BYTE_W-1:0] i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_inst_mem_wr_en,
  output logic [NBITS-1:0]  o_inst_mem_addr,
  output logic [NBITS-1:0]  o_inst_mem_data,
  output logic              o_cpu_rst,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam logic [15:0] MAX_W16 = 16'(MAX_WORDS);

  state_e             state_q, state_d;
  logic [15:0]        count_q, count_d;
  logic [15:0]        idx_q, idx_d;
  logic               wr_en_q, wr_en_d;
  logic [NBITS-1:0]   addr_q, addr_d;
  logic [NBITS-1:0]   data_q, data_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [15:0]        count_full;
  logic [31:0]        word;
  logic               word_ready;
`ifdef DEBUG_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0]  chk_q, chk_d;
`endif

  byte_word_assembler u_asm (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_clear      (state_q == IDLE),
    .i_byte       (i_rx_data),
    .i_valid      (i_rx_valid && (state_q == DATA)),
    .o_word       (word),
    .o_word_ready (word_ready)
  );

  assign count_full = {i_rx_data, count_q[7:0]};

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    wr_en_d = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef DEBUG_LOADER_CHECKSUM_EN
    chk_d   = chk_q;
`endif
    if (i_rx_valid) begin
      case (state_q)
        IDLE: begin
          if (i_rx_data == CMD_LOAD) begin
            state_d = CNT_LO;
            count_d = 16'd0;
            idx_d   = 16'd0;
`ifdef DEBUG_LOADER_CHECKSUM_EN
            chk_d   = '0;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
        CNT_LO: begin
          count_d = {8'h00, i_rx_data};
          state_d = CNT_HI;
        end
        CNT_HI: begin
          count_d = count_full;
          if (count_full > MAX_W16) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else if (count_full == 16'd0) begin
`ifdef DEBUG_LOADER_CHECKSUM_EN
            state_d = CHK;
`else
            done_d  = 1'b1;
            state_d = IDLE;
`endif
          end else begin
            state_d = DATA;
          end
        end
        DATA: begin
`ifdef DEBUG_LOADER_CHECKSUM_EN
          chk_d = chk_q ^ i_rx_data;
`endif
          if (word_ready) begin
            wr_en_d = 1'b1;
            addr_d  = NBITS'(idx_q) << 2;
            data_d  = NBITS'(word);
            idx_d   = idx_q + 16'd1;
            if (idx_q == count_q - 16'd1) begin
`ifdef DEBUG_LOADER_CHECKSUM_EN
              state_d = CHK;
`else
              done_d  = 1'b1;
              state_d = IDLE;
`endif
            end
          end
        end
`ifdef DEBUG_LOADER_CHECKSUM_EN
        CHK: begin
          if (i_rx_data == chk_q) done_d = 1'b1;
          else                    err_d  = 1'b1;
          state_d = IDLE;
        end
`endif
        default: state_d = IDLE;
      endcase
    end
    // Busy mirrors the state being entered, so it drops with the final pulse.
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      count_q <= 16'd0;
      idx_q   <= 16'd0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef DEBUG_LOADER_CHECKSUM_EN
      chk_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef DEBUG_LOADER_CHECKSUM_EN
      chk_q   <= chk_d;
`endif
    end
  end

  assign o_inst_mem_wr_en = wr_en_q;
  assign o_inst_mem_addr  = addr_q;
  assign o_inst_mem_data  = data_q;
  assign o_cpu_rst        = busy_q;
  assign o_busy           = busy_q;
  assign o_done           = done_q;
  assign o_err            = err_q;

endmodule

// File: tb/tb_debug_inst_loader.sv
module tb_debug_inst_loader;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        wr_en;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic        err;

  int compared   = 0;
  int mismatched = 0;

  debug_inst_loader dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_rx_data        (rx_data),
    .i_rx_valid       (rx_valid),
    .o_inst_mem_wr_en (wr_en),
    .o_inst_mem_addr  (addr),
    .o_inst_mem_data  (wdata),
    .o_cpu_rst        (cpu_rst),
    .o_busy           (busy),
    .o_done           (done),
    .o_err            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic        v;
    logic [7:0]  d;
    logic        we;
    logic [31:0] a;
    logic [31:0] dt;
    logic        cr;
    logic        bz;
    logic        dn;
    logic        er;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] ea;
  logic [31:0] ed;

  task automatic row(input logic r, input logic v, input logic [7:0] d,
                     input logic we, input logic bz, input logic dn, input logic er);
    vec_t t;
    t.r = r; t.v = v; t.d = d; t.we = we; t.a = ea; t.dt = ed;
    t.cr = bz; t.bz = bz; t.dn = dn; t.er = er;
    tbl.push_back(t);
  endtask

  // Applies one cycle of input, then samples 1 time unit after the edge.
  task automatic drive(input logic r, input logic v, input logic [7:0] d);
    @(negedge clk);
    rst = r; rx_valid = v; rx_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [95:0] act, input logic [95:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    ea = 32'h0; ed = 32'h0;

    // reset state
    row(1, 0, 8'h00, 0, 0, 0, 0);
    row(0, 0, 8'h00, 0, 0, 0, 0);
    // reset in the middle of DATA
    row(0, 1, 8'h4C, 0, 1, 0, 0);
    row(0, 1, 8'h02, 0, 1, 0, 0);
    row(0, 1, 8'h00, 0, 1, 0, 0);
    row(0, 1, 8'hAA, 0, 1, 0, 0);
    row(1, 0, 8'h00, 0, 0, 0, 0);
    // basic two-word load, fresh from address 0
    row(0, 1, 8'h4C, 0, 1, 0, 0);
    row(0, 1, 8'h02, 0, 1, 0, 0);
    row(0, 1, 8'h00, 0, 1, 0, 0);
    row(0, 1, 8'h78, 0, 1, 0, 0);
    row(0, 1, 8'h56, 0, 1, 0, 0);
    row(0, 1, 8'h34, 0, 1, 0, 0);
    ea = 32'h0; ed = 32'h12345678;
    row(0, 1, 8'h12, 1, 1, 0, 0);
    row(0, 1, 8'hEF, 0, 1, 0, 0);
    row(0, 1, 8'hBE, 0, 1, 0, 0);
    row(0, 1, 8'hAD, 0, 1, 0, 0);
    ea = 32'h4; ed = 32'hDEADBEEF;
`ifdef DEBUG_LOADER_CHECKSUM_EN
    row(0, 1, 8'hDE, 1, 1, 0, 0);
    row(0, 1, 8'h2A, 0, 0, 1, 0);
`else
    row(0, 1, 8'hDE, 1, 0, 1, 0);
`endif
    row(0, 0, 8'h00, 0, 0, 0, 0);
    // bad command byte
    row(0, 1, 8'h55, 0, 0, 0, 1);
    row(0, 0, 8'h00, 0, 0, 0, 0);
    // count 257 rejected
    row(0, 1, 8'h4C, 0, 1, 0, 0);
    row(0, 1, 8'h01, 0, 1, 0, 0);
    row(0, 1, 8'h01, 0, 0, 0, 1);
    row(0, 0, 8'h00, 0, 0, 0, 0);
    // count 0
    row(0, 1, 8'h4C, 0, 1, 0, 0);
    row(0, 1, 8'h00, 0, 1, 0, 0);
`ifdef DEBUG_LOADER_CHECKSUM_EN
    row(0, 1, 8'h00, 0, 1, 0, 0);
    row(0, 1, 8'h00, 0, 0, 1, 0);
`else
    row(0, 1, 8'h00, 0, 0, 1, 0);
`endif
    row(0, 0, 8'h00, 0, 0, 0, 0);
    // back-to-back single-word load
    row(0, 1, 8'h4C, 0, 1, 0, 0);
    row(0, 1, 8'h01, 0, 1, 0, 0);
    row(0, 1, 8'h00, 0, 1, 0, 0);
    row(0, 1, 8'h01, 0, 1, 0, 0);
    row(0, 1, 8'h02, 0, 1, 0, 0);
    row(0, 1, 8'h03, 0, 1, 0, 0);
    ea = 32'h0; ed = 32'h04030201;
`ifdef DEBUG_LOADER_CHECKSUM_EN
    row(0, 1, 8'h04, 1, 1, 0, 0);
    row(0, 1, 8'h04, 0, 0, 1, 0);
    row(0, 1, 8'h4C, 0, 1, 0, 0);
    row(0, 1, 8'h01, 0, 1, 0, 0);
    row(0, 1, 8'h00, 0, 1, 0, 0);
    row(0, 1, 8'h01, 0, 1, 0, 0);
    row(0, 1, 8'h02, 0, 1, 0, 0);
    row(0, 1, 8'h03, 0, 1, 0, 0);
    row(0, 1, 8'h04, 1, 1, 0, 0);
    row(0, 1, 8'h05, 0, 0, 0, 1);
`else
    row(0, 1, 8'h04, 1, 0, 1, 0);
`endif
    row(0, 0, 8'h00, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].v, tbl[i].d);
      check($sformatf("row%0d", i),
            96'({wr_en, addr, wdata, cpu_rst, busy, done, err}),
            96'({tbl[i].we, tbl[i].a, tbl[i].dt, tbl[i].cr, tbl[i].bz, tbl[i].dn, tbl[i].er}));
    end

    // Bytes separated by idle cycles still assemble into one word.
    drive(0, 1, 8'h4C); drive(0, 0, 8'h00);
    drive(0, 1, 8'h01); drive(0, 0, 8'h00);
    drive(0, 1, 8'h00); drive(0, 0, 8'h00);
    drive(0, 1, 8'h11); drive(0, 0, 8'h00);
    drive(0, 1, 8'h22); drive(0, 0, 8'h00);
    drive(0, 1, 8'h33); drive(0, 0, 8'h00);
    check("gap_we_early", 96'(wr_en), 96'(0));
    drive(0, 1, 8'h44);
    check("gap_we", 96'(wr_en), 96'(1));
    check("gap_data", 96'(wdata), 96'(32'h44332211));
    check("gap_addr", 96'(addr), 96'(32'h0));
`ifdef DEBUG_LOADER_CHECKSUM_EN
    check("gap_busy", 96'(busy), 96'(1));
    drive(0, 0, 8'h00);
    check("gap_busy_wait", 96'(busy), 96'(1));
    drive(0, 1, 8'h44);
`endif
    check("gap_done", 96'({done, err, busy}), 96'(3'b100));
    drive(0, 0, 8'h00);
    check("gap_done_clear", 96'(done), 96'(0));

    // Count equal to MAX_WORDS is accepted.
    drive(0, 1, 8'h4C);
    drive(0, 1, 8'h00);
    drive(0, 1, 8'h01);
    check("max_count_ok", 96'({err, busy, cpu_rst}), 96'(3'b011));
    drive(0, 1, 8'hA5);
    check("max_count_data", 96'({err, busy, wr_en}), 96'(3'b010));
    drive(1, 0, 8'h00);
    check("max_count_rst", 96'({wr_en, cpu_rst, busy, done, err}), 96'(5'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
